mult_cmd_driver: RTL and testbench
==================================

# mult_cmd_driver

Upstream command stage for the parity-protected 16-bit multiplier (`vdic_dut_2023`). It accepts operand pairs on a valid/ready stream, buffers them in a small FIFO, and generates even-parity bits. It runs the multiplier's req/ack handshake one operation at a time and returns each result with error and timeout status through a holding register.

## Interface
- `DATA_W`, 16: operand width; result width is 2*DATA_W.
- `FIFO_DEPTH`, 4: operand FIFO entries (power of two, ≥2).
- `TIMEOUT`, 255: max cycles from req assertion to result_rdy before abort (≥2).

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept; equals !full.
- `in_a` in DATA_W: operand A, signed.
- `in_b` in DATA_W: operand B, signed.
- `in_inject_err` in 1: store inverted arg_a parity for this entry.
- `arg_a` out DATA_W: operand A to multiplier.
- `arg_a_parity` out 1: ^arg_a, or inverted if injected.
- `arg_b` out DATA_W: operand B to multiplier.
- `arg_b_parity` out 1: ^arg_b.
- `req` out 1: request to multiplier.
- `ack` in 1: multiplier accepted operands.
- `result` in 2*DATA_W: multiplier product.
- `result_parity` in 1: parity of result.
- `result_rdy` in 1: one-cycle result strobe.
- `arg_parity_error` in 1: multiplier detected bad argument parity; qualified by result_rdy.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes result.
- `out_result` out 2*DATA_W: captured product (0 on timeout).
- `out_par_err` out 1: captured arg_parity_error.
- `out_res_par_bad` out 1: result_parity != ^result at capture.
- `out_timeout` out 1: operation aborted by timeout.
- `stray_rdy` out 1: sticky; result_rdy seen outside WAIT_RES.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- FIFO stores {in_inject_err, in_a, in_b}. Push on in_valid && in_ready. Pop only by the FSM in IDLE. Push and pop in the same edge are both performed. in_ready does not look at the pop (no pass-through when full).
- Parity is even: parity bit = XOR of all operand bits. It is computed when the entry is popped and registered with the arg_* outputs.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop, load arg_*, set req=1, clear the timeout counter, go to REQ.
  - REQ: req held high. When ack is sampled high, set req=0 and go to WAIT_RES. ack sampled in the first REQ cycle is valid.
  - WAIT_RES: when result_rdy is sampled high, capture result and flags, set out_valid=1, go to HOLD.
  - HOLD: out_* stable. When out_valid && out_ready, set out_valid=0 and go to IDLE.
  - Timeout: the counter increments every cycle in REQ and WAIT_RES. When it reaches TIMEOUT-1 without result_rdy, set req=0, out_result=0, out_timeout=1, out_valid=1, go to HOLD. If result_rdy arrives in that same cycle, the result wins and out_timeout=0.
- ack outside REQ is ignored. result_rdy outside WAIT_RES is ignored and sets stray_rdy.
- arg_* hold their values until the next pop.

## Timing
- Reset values (asynchronous): req=0, all arg_* and parity bits 0, out_valid=0, out_result=0, all out flags 0, stray_rdy=0, FIFO empty (in_ready=1), FSM IDLE, busy=0.
- All outputs are registered except in_ready (decoded from FIFO count) and busy.
- Latency:
  - Pair pushed at edge 0 with FSM idle: req=1 after edge 1.
  - ack sampled at edge k: req=0 after edge k.
  - result_rdy sampled at edge m: out_valid=1 after edge m.
  - Handoff at edge h: next pop no earlier than edge h+1.
- Throughput: one operation in flight; back-pressure on out_ready stalls issue, not FIFO fill.
- Reset asserted mid-operation: req drops immediately, FIFO contents and the held result are discarded.

## Test plan
- a=0x0003, b=0xFFFE, no injection; model acks at cycle 1 and returns 0xFFFF_FFFA with parity 0 three cycles later. Required: arg_a_parity=0, arg_b_parity=1, out_result=0xFFFF_FFFA, all flags 0.
- Same pair with in_inject_err=1; model returns arg_parity_error=1. Required: arg_a_parity=1, out_par_err=1.
- Model returns 0x0000_0006 with result_parity=1. Required: out_res_par_bad=1.
- TIMEOUT=8 and ack never asserted. Required: req falls and out_valid=1 with out_timeout=1 and out_result=0 exactly 8 cycles after req rose.
- in_valid held high, ack held low. Required: 5 pairs accepted, in_ready=0 from then on. Ack, result, and out_ready all held high: the 5 results emerge in input order.
- rst_n pulsed low while in WAIT_RES with 2 entries queued. Required: req=0, out_valid=0, in_ready=1, busy=0 immediately; a later result_rdy sets stray_rdy only.

Source files
------------

// File: rtl/mult_cmd_driver.sv
// Upstream command stage for the parity-protected multiplier: operand FIFO,
// even-parity generation, req/ack issue with timeout, and a result holding
// register handed off on a valid/ready stream.
module mult_cmd_driver #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  input  logic                  in_inject_err,
  output logic [DATA_W-1:0]     arg_a,
  output logic                  arg_a_parity,
  output logic [DATA_W-1:0]     arg_b,
  output logic                  arg_b_parity,
  output logic                  req,
  input  logic                  ack,
  input  logic [2*DATA_W-1:0]   result,
  input  logic                  result_parity,
  input  logic                  result_rdy,
  input  logic                  arg_parity_error,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_result,
  output logic                  out_par_err,
  output logic                  out_res_par_bad,
  output logic                  out_timeout,
  output logic                  stray_rdy,
  output logic                  busy
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int EW    = 2 * DATA_W + 1;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RES,
    S_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [EW-1:0]       w_head;

  logic [TW-1:0]       r_tcnt;
  logic                w_tlimit;
  logic                w_capture;
  logic                w_abort;
  logic                w_handoff;

  logic                r_req;
  logic [DATA_W-1:0]   r_arg_a;
  logic [DATA_W-1:0]   r_arg_b;
  logic                r_arg_a_par;
  logic                r_arg_b_par;
  logic                r_out_valid;
  logic [2*DATA_W-1:0] r_out_result;
  logic                r_out_par_err;
  logic                r_out_res_par_bad;
  logic                r_out_timeout;
  logic                r_stray;

  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rptr];
  assign w_tlimit = (r_tcnt == TW'(TIMEOUT - 1));

  assign in_ready        = !w_full;
  assign busy            = (r_state != S_IDLE) || !w_empty;
  assign req             = r_req;
  assign arg_a           = r_arg_a;
  assign arg_b           = r_arg_b;
  assign arg_a_parity    = r_arg_a_par;
  assign arg_b_parity    = r_arg_b_par;
  assign out_valid       = r_out_valid;
  assign out_result      = r_out_result;
  assign out_par_err     = r_out_par_err;
  assign out_res_par_bad = r_out_res_par_bad;
  assign out_timeout     = r_out_timeout;
  assign stray_rdy       = r_stray;

  // FIFO storage: entries are {inject, a, b}; storage needs no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_inject_err, in_a, in_b};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and per-edge control strobes; timeout beats a late ack,
  // a result arriving on the limit cycle beats the timeout
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    w_handoff   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_tlimit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (ack) begin
          w_state_nxt = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (result_rdy) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (w_tlimit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_handoff   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // req is high exactly while the FSM sits in REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_req <= 1'b0;
    else        r_req <= (w_state_nxt == S_REQ);
  end

  // Operation timer: cleared on issue, counts in REQ/WAIT_RES, saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (w_pop) begin
      r_tcnt <= '0;
    end else if ((r_state == S_REQ || r_state == S_WAIT_RES) && !w_tlimit) begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // Operand registers with even parity, loaded on pop and held until the next pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arg_a     <= '0;
      r_arg_b     <= '0;
      r_arg_a_par <= 1'b0;
      r_arg_b_par <= 1'b0;
    end else if (w_pop) begin
      r_arg_a     <= w_head[2*DATA_W-1:DATA_W];
      r_arg_b     <= w_head[DATA_W-1:0];
      r_arg_a_par <= (^w_head[2*DATA_W-1:DATA_W]) ^ w_head[EW-1];
      r_arg_b_par <= ^w_head[DATA_W-1:0];
    end
  end

  // Result holding register: capture, timeout abort, consumer handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid       <= 1'b0;
      r_out_result      <= '0;
      r_out_par_err     <= 1'b0;
      r_out_res_par_bad <= 1'b0;
      r_out_timeout     <= 1'b0;
    end else if (w_capture) begin
      r_out_valid       <= 1'b1;
      r_out_result      <= result;
      r_out_par_err     <= arg_parity_error;
      r_out_res_par_bad <= result_parity ^ (^result);
      r_out_timeout     <= 1'b0;
    end else if (w_abort) begin
      r_out_valid       <= 1'b1;
      r_out_result      <= '0;
      r_out_par_err     <= 1'b0;
      r_out_res_par_bad <= 1'b0;
      r_out_timeout     <= 1'b1;
    end else if (w_handoff) begin
      r_out_valid       <= 1'b0;
    end
  end

  // Sticky flag for result strobes arriving when no result is awaited
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_stray <= 1'b0;
    else if (result_rdy && r_state != S_WAIT_RES) r_stray <= 1'b1;
  end

endmodule

// File: tb/tb_mult_cmd_driver.sv
// Bench for mult_cmd_driver: a transaction-level model (operand queue, one
// operation in flight, edge counts since req rose) plus a multiplier responder.
module tb_mult_cmd_driver;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  typedef struct packed {
    logic          inj;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          in_inject_err = 1'b0;
  logic [DW-1:0] arg_a;
  logic          arg_a_parity;
  logic [DW-1:0] arg_b;
  logic          arg_b_parity;
  logic          req;
  logic          ack = 1'b0;
  logic [31:0]   result = '0;
  logic          result_parity = 1'b0;
  logic          result_rdy = 1'b0;
  logic          arg_parity_error = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_result;
  logic          out_par_err;
  logic          out_res_par_bad;
  logic          out_timeout;
  logic          stray_rdy;
  logic          busy;

  mult_cmd_driver #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_inject_err(in_inject_err),
    .arg_a(arg_a), .arg_a_parity(arg_a_parity), .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .req(req), .ack(ack), .result(result), .result_parity(result_parity),
    .result_rdy(result_rdy), .arg_parity_error(arg_parity_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_par_err(out_par_err), .out_res_par_bad(out_res_par_bad),
    .out_timeout(out_timeout), .stray_rdy(stray_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int n_push = 0;

  // model state
  ent_t        mq[$];
  ent_t        cur;
  int          phase;       // 0 idle, 1 requesting, 2 awaiting result, 3 holding
  int          t;           // edges since req rose
  int          ack_at, res_at;
  bit          corrupt;
  bit          have_op;
  bit          e_stray;
  logic [31:0] e_res;
  bit          e_perr, e_rpb, e_to;
  logic [31:0] dut_hist[$];

  // responder controls
  bit f_use;
  int f_ack, f_res;
  bit f_cor;
  bit noise_en;

  function automatic logic [31:0] prod(ent_t e);
    logic signed [31:0] sa, sb;
    sa = $signed(e.a);
    sb = $signed(e.b);
    return sa * sb;
  endfunction

  function automatic bit epar(logic [31:0] x);
    return ($countones(x) % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    phase = 0; t = 0; have_op = 0; e_stray = 0;
    cur = '0; e_res = '0; e_perr = 0; e_rpb = 0; e_to = 0;
  endtask

  task automatic pick_op();
    if (f_use) begin
      ack_at = f_ack; res_at = f_res; corrupt = f_cor;
    end else begin
      ack_at  = 1 + int'($urandom % 9);
      res_at  = ack_at + 1 + int'($urandom % 5);
      corrupt = ($urandom % 6) == 0;
    end
  endtask

  task automatic check_all();
    chk("req", req, phase == 1);
    chk("out_valid", out_valid, phase == 3);
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("busy", busy, phase != 0 || mq.size() != 0);
    chk("stray_rdy", stray_rdy, e_stray);
    if (have_op) begin
      chk("arg_a", arg_a, cur.a);
      chk("arg_b", arg_b, cur.b);
      chk("arg_a_parity", arg_a_parity, epar(32'(cur.a)) ^ cur.inj);
      chk("arg_b_parity", arg_b_parity, epar(32'(cur.b)));
    end else begin
      chk("arg_a_rst", {arg_a, arg_a_parity}, '0);
      chk("arg_b_rst", {arg_b, arg_b_parity}, '0);
    end
    if (phase == 3) begin
      chk("out_result", out_result, e_res);
      chk("out_par_err", out_par_err, e_perr);
      chk("out_res_par_bad", out_res_par_bad, e_rpb);
      chk("out_timeout", out_timeout, e_to);
    end
  endtask

  task automatic drive_resp();
    ack = 1'b0;
    result_rdy = 1'b0;
    result = $urandom;
    result_parity = 1'($urandom);
    arg_parity_error = 1'($urandom);
    if (phase == 1 && t + 1 == ack_at) ack = 1'b1;
    else if (phase != 1 && noise_en && ($urandom % 4) == 0) ack = 1'b1;
    if (phase == 2 && t + 1 == res_at) begin
      result_rdy = 1'b1;
      result = prod(cur);
      result_parity = epar(prod(cur)) ^ corrupt;
      arg_parity_error = cur.inj;
    end
  endtask

  // one clock: advance the model by the inputs seen at this edge, then check
  task automatic step();
    bit   push, ack_v, rdy_v, ordy_v;
    ent_t pe;
    push   = in_valid && (mq.size() < DEPTH);
    pe     = {in_inject_err, in_a, in_b};
    ack_v  = ack;
    rdy_v  = result_rdy;
    ordy_v = out_ready;
    if (phase == 3 && ordy_v) dut_hist.push_back(out_result);
    @(posedge clk);
    #1;
    ncyc++;
    if (rdy_v && phase != 2) e_stray = 1;
    case (phase)
      0: if (mq.size() != 0) begin
           cur = mq.pop_front(); phase = 1; t = 0; have_op = 1; pick_op();
         end
      1: begin
           t++;
           if (t == TO) begin phase = 3; e_res = '0; e_perr = 0; e_rpb = 0; e_to = 1; end
           else if (ack_v) phase = 2;
         end
      2: begin
           t++;
           if (rdy_v) begin
             phase = 3; e_res = prod(cur); e_perr = cur.inj; e_rpb = corrupt; e_to = 0;
           end else if (t == TO) begin
             phase = 3; e_res = '0; e_perr = 0; e_rpb = 0; e_to = 1;
           end
         end
      default: if (ordy_v) phase = 0;
    endcase
    if (push) begin mq.push_back(pe); n_push++; end
    check_all();
    drive_resp();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 0; ack = 0; result_rdy = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_out_valid(input int maxc);
    int n = 0;
    while (out_valid !== 1'b1 && n < maxc) begin step(); n++; end
    chk("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic push_one(input logic [15:0] a, input logic [15:0] b, input logic inj);
    in_a = a; in_b = b; in_inject_err = inj; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int r, n, base, hb;
    logic [31:0] exp5 [5];
    f_use = 1; f_ack = 1; f_res = 4; f_cor = 0; noise_en = 0;
    model_reset();
    do_reset();

    // reset state
    chk("rst_req", req, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {out_result, out_par_err, out_res_par_bad, out_timeout, stray_rdy}, '0);

    // basic product, no injection
    f_ack = 1; f_res = 4; f_cor = 0;
    push_one(16'h0003, 16'hFFFE, 1'b0);
    wait_out_valid(20);
    chk("t1_arg_a_parity", arg_a_parity, 1'b0);
    chk("t1_arg_b_parity", arg_b_parity, 1'b1);
    chk("t1_out_result", out_result, 32'hFFFF_FFFA);
    chk("t1_flags", {out_par_err, out_res_par_bad, out_timeout}, 3'b000);
    handoff();

    // injected argument parity error
    push_one(16'h0003, 16'hFFFE, 1'b1);
    wait_out_valid(20);
    chk("t2_arg_a_parity", arg_a_parity, 1'b1);
    chk("t2_out_par_err", out_par_err, 1'b1);
    handoff();

    // bad result parity
    f_cor = 1;
    push_one(16'h0002, 16'h0003, 1'b0);
    wait_out_valid(20);
    chk("t3_out_result", out_result, 32'h0000_0006);
    chk("t3_out_res_par_bad", out_res_par_bad, 1'b1);
    handoff();
    f_cor = 0;

    // timeout with ack never asserted
    f_ack = 1000; f_res = 1000;
    push_one(16'h1234, 16'h0005, 1'b0);
    n = 0;
    while (req !== 1'b1 && n < 5) begin step(); n++; end
    chk("t4_req_rose", req, 1'b1);
    r = ncyc;
    wait_out_valid(20);
    chk("t4_latency", 64'(ncyc - r), 64'd8);
    chk("t4_req_low", req, 1'b0);
    chk("t4_out_timeout", out_timeout, 1'b1);
    chk("t4_out_result", out_result, 32'h0);
    handoff();

    // fill with ack held off, then drain in order
    do_reset();
    base = n_push;
    in_valid = 1'b1; in_b = 16'h0010; in_inject_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_a = 16'(n_push - base + 1);
      step();
    end
    in_valid = 1'b0;
    chk("t5_accepted", 64'(n_push - base), 64'd5);
    chk("t5_in_ready", in_ready, 1'b0);
    f_ack = 1; f_res = 2;
    out_ready = 1'b1;
    hb = dut_hist.size();
    n = 0;
    while (dut_hist.size() - hb < 5 && n < 200) begin step(); n++; end
    out_ready = 1'b0;
    chk("t5_results", 64'(dut_hist.size() - hb), 64'd5);
    exp5 = '{32'h0, 32'h20, 32'h30, 32'h40, 32'h50};
    for (int i = 0; i < 5; i++)
      if (hb + i < dut_hist.size()) chk("t5_order", dut_hist[hb + i], exp5[i]);

    // reset while awaiting a result with two entries queued
    do_reset();
    f_ack = 1; f_res = 1000;
    for (int i = 0; i < 3; i++) push_one(16'(i + 7), 16'h0003, 1'b0);
    n = 0;
    while (phase != 2 && n < 10) begin step(); n++; end
    chk("t6_in_wait", {req, out_valid, busy}, 3'b001);
    #2 rst_n = 1'b0;
    ack = 1'b0; result_rdy = 1'b0;
    #1;
    chk("t6_req", req, 1'b0);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    result_rdy = 1'b1;
    result = 32'h1;
    step();
    chk("t6_stray", stray_rdy, 1'b1);
    chk("t6_no_out", out_valid, 1'b0);

    // randomized traffic
    do_reset();
    f_use = 0; noise_en = 1;
    for (int i = 0; i < 3000; i++) begin
      in_valid      = ($urandom % 3) != 0;
      in_a          = 16'($urandom);
      in_b          = 16'($urandom);
      in_inject_err = ($urandom % 5) == 0;
      out_ready     = ($urandom % 2) == 1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; noise_en = 0;
    n = 0;
    while ((phase != 0 || mq.size() != 0) && n < 500) begin step(); n++; end
    chk("drain_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
